// File: rtl/hpgp_turbo_duobin_enc.sv
// HPGP duo-binary turbo encoder: two 8-state RSC encoders (natural/interleaved),
// registered systematic + parity outputs with rate-16/21 puncture keep flags.
module hpgp_turbo_duobin_enc #(
  parameter logic [7:0] P1_MASK = 8'b0100_1001,
  parameter logic [7:0] P2_MASK = 8'b0010_0010
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] pb_size,
  input  logic       code_rate,
  input  logic [1:0] din_nat,
  input  logic [1:0] din_itl,
  input  logic       din_vld,
  output logic [1:0] sys,
  output logic       p1,
  output logic       p2,
  output logic       p1_keep,
  output logic       p2_keep,
  output logic       dout_vld,
  output logic       pb_last,
  output logic       pb_done,
  output logic [2:0] fstate1,
  output logic [2:0] fstate2,
  output logic       cfg_err
);

  typedef enum logic [1:0] {
    IDLE, RUN, DONE, ERR
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  st1, st2;
  logic [11:0] k;
  logic [1:0]  size_q;
  logic        rate_q;

  logic [1:0]  size_e;
  logic        rate_e;
  logic [11:0] k_last;
  logic        enc_en;
  logic        last;
  logic        bad;
  logic        done_st;
  logic [3:0]  e1, e2;

  // returns {parity, next_state}; state is {s1,s2,s3}
  function automatic logic [3:0] enc_step(
    input logic [2:0] s,
    input logic [1:0] d
  );
    logic fb;
    fb = d[1] ^ d[0] ^ s[1] ^ s[0];
    return {fb ^ s[2] ^ s[0], fb, s[2] ^ d[0], s[1] ^ d[0]};
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (din_vld) state_nx = bad ? ERR : RUN;
      RUN:  if (last)    state_nx = DONE;
      DONE:              state_nx = IDLE;
      ERR:               state_nx = ERR;
      default:           state_nx = IDLE;
    endcase
  end

  // The first pair of a PB uses the live config; later pairs the latched one.
  always_comb begin
    size_e  = (state == IDLE) ? pb_size : size_q;
    rate_e  = (state == IDLE) ? code_rate : rate_q;
    k_last  = 12'd2079;
    unique case (size_e)
      2'd0:    k_last = 12'd63;
      2'd1:    k_last = 12'd543;
      default: k_last = 12'd2079;
    endcase
    bad     = (state == IDLE) && din_vld && (pb_size == 2'd3);
    enc_en  = din_vld && (((state == IDLE) && !bad) || (state == RUN));
    last    = enc_en && (k == k_last);
    done_st = (state == DONE);
    e1      = enc_step(st1, din_nat);
    e2      = enc_step(st2, din_itl);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      st1      <= '0;
      st2      <= '0;
      k        <= '0;
      size_q   <= '0;
      rate_q   <= 1'b0;
      sys      <= '0;
      p1       <= 1'b0;
      p2       <= 1'b0;
      p1_keep  <= 1'b0;
      p2_keep  <= 1'b0;
      dout_vld <= 1'b0;
      pb_last  <= 1'b0;
      pb_done  <= 1'b0;
      fstate1  <= '0;
      fstate2  <= '0;
      cfg_err  <= 1'b0;
    end else begin
      dout_vld <= enc_en;
      pb_last  <= last;
      pb_done  <= done_st;
      if (bad) cfg_err <= 1'b1;
      if ((state == IDLE) && enc_en) begin
        size_q <= pb_size;
        rate_q <= code_rate;
      end
      if (done_st) begin
        fstate1 <= st1;
        fstate2 <= st2;
        st1     <= '0;
        st2     <= '0;
        k       <= '0;
      end
      if (enc_en) begin
        sys     <= din_nat;
        p1      <= e1[3];
        p2      <= e2[3];
        st1     <= e1[2:0];
        st2     <= e2[2:0];
        k       <= k + 12'd1;
        p1_keep <= rate_e ? P1_MASK[k[2:0]] : 1'b1;
        p2_keep <= rate_e ? P2_MASK[k[2:0]] : 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hpgp_turbo_duobin_enc.sv
// Scoreboard bench for hpgp_turbo_duobin_enc: stimulus pushes expectations,
// a negedge monitor pops and compares on dout_vld / pb_done.
module tb_hpgp_turbo_duobin_enc;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [1:0] pb_size = 2'd0;
  logic       code_rate = 1'b0;
  logic [1:0] din_nat = 2'd0;
  logic [1:0] din_itl = 2'd0;
  logic       din_vld = 1'b0;
  logic [1:0] sys;
  logic       p1, p2, p1_keep, p2_keep;
  logic       dout_vld, pb_last, pb_done, cfg_err;
  logic [2:0] fstate1, fstate2;

  hpgp_turbo_duobin_enc dut (
    .clk(clk), .n_rst(n_rst), .pb_size(pb_size), .code_rate(code_rate),
    .din_nat(din_nat), .din_itl(din_itl), .din_vld(din_vld),
    .sys(sys), .p1(p1), .p2(p2), .p1_keep(p1_keep), .p2_keep(p2_keep),
    .dout_vld(dout_vld), .pb_last(pb_last), .pb_done(pb_done),
    .fstate1(fstate1), .fstate2(fstate2), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sys;
    logic       p1, p2, k1, k2, last;
  } exp_t;

  localparam logic [7:0] M1 = 8'b0100_1001;
  localparam logic [7:0] M2 = 8'b0010_0010;

  exp_t       q[$];
  logic [5:0] fq[$];
  exp_t       em;
  logic [5:0] fm;
  int ncmp = 0, nerr = 0;
  int nvld = 0, nlast = 0, ndone = 0, nkeep = 0;
  logic prev_last = 1'b0;

  logic [2:0] m1 = '0, m2 = '0;
  int   mk = 0, mn = 64;
  logic mrate = 1'b0, mbusy = 1'b0, merr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    ncmp++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [3:0] step(input logic [2:0] s,
                                      input logic [1:0] d);
    logic a, b, s1, s2, s3, fb;
    a = d[1]; b = d[0];
    s1 = s[2]; s2 = s[1]; s3 = s[0];
    fb = a ^ b ^ s2 ^ s3;
    return {fb ^ s1 ^ s3, fb, s1 ^ b, s2 ^ b};
  endfunction

  always @(negedge clk) begin
    if (dout_vld) begin
      nvld++;
      nkeep += int'(p1_keep) + int'(p2_keep);
      if (pb_last) nlast++;
      if (q.size() == 0) chk("spurious_vld", 32'd1, 32'd0);
      else begin
        em = q.pop_front();
        chk("sys", 32'(sys), 32'(em.sys));
        chk("p1", 32'(p1), 32'(em.p1));
        chk("p2", 32'(p2), 32'(em.p2));
        chk("p1_keep", 32'(p1_keep), 32'(em.k1));
        chk("p2_keep", 32'(p2_keep), 32'(em.k2));
        chk("pb_last", 32'(pb_last), 32'(em.last));
      end
    end else if (pb_last) chk("last_no_vld", 32'd1, 32'd0);
    if (pb_done) begin
      ndone++;
      chk("done_after_last", 32'(prev_last), 32'd1);
      if (fq.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else begin
        fm = fq.pop_front();
        chk("fstate1", 32'(fstate1), 32'(fm[5:3]));
        chk("fstate2", 32'(fstate2), 32'(fm[2:0]));
      end
    end
    prev_last = pb_last && dout_vld;
  end

  task automatic send(input logic [1:0] nat, input logic [1:0] itl);
    exp_t e;
    logic [3:0] r1, r2;
    if (!merr && !mbusy) begin
      if (pb_size == 2'd3) merr = 1'b1;
      else begin
        mbusy = 1'b1;
        mn = (pb_size == 2'd0) ? 64 : (pb_size == 2'd1) ? 544 : 2080;
        mrate = code_rate;
        mk = 0;
      end
    end
    if (mbusy) begin
      r1 = step(m1, nat);
      r2 = step(m2, itl);
      e.sys = nat;
      e.p1 = r1[3];
      e.p2 = r2[3];
      e.k1 = mrate ? M1[mk % 8] : 1'b1;
      e.k2 = mrate ? M2[mk % 8] : 1'b1;
      e.last = (mk == mn - 1);
      q.push_back(e);
      m1 = r1[2:0];
      m2 = r2[2:0];
      mk++;
      if (mk == mn) begin
        fq.push_back({m1, m2});
        m1 = '0; m2 = '0; mbusy = 1'b0;
      end
    end
    din_nat = nat;
    din_itl = itl;
    din_vld = 1'b1;
    @(posedge clk); #1;
    din_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    din_vld = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    nvld = 0; nlast = 0; ndone = 0; nkeep = 0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    din_vld = 1'b0;
    m1 = '0; m2 = '0; mbusy = 1'b0; merr = 1'b0;
    q.delete();
    fq.delete();
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  function automatic logic [1:0] rnd2();
    return 2'($urandom_range(3, 0));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    do_reset();
    chk("reset_outs",
        32'({sys, p1, p2, p1_keep, p2_keep, dout_vld, pb_last, pb_done,
             fstate1, fstate2, cfg_err}), 32'd0);

    // 1) all-zero 64-pair PB, rate 1/2
    clr();
    pb_size = 2'd0; code_rate = 1'b0;
    repeat (64) send(2'b00, 2'b00);
    idle(3);
    chk("t1_nvld", 32'(nvld), 32'd64);
    chk("t1_nlast", 32'(nlast), 32'd1);
    chk("t1_ndone", 32'(ndone), 32'd1);
    chk("t1_keep", 32'(nkeep), 32'd128);

    // 2) hand-computed first pairs
    do_reset();
    clr();
    send(2'b01, 2'b00);
    @(negedge clk);
    chk("t2_sys", 32'(sys), 32'd1);
    chk("t2_p1_a", 32'(p1), 32'd1);
    send(2'b10, 2'b00);
    @(negedge clk);
    chk("t2_p1_b", 32'(p1), 32'd1);
    chk("t2_sys_b", 32'(sys), 32'd2);
    repeat (62) send(2'b00, 2'b00);
    idle(3);
    chk("t2_nvld", 32'(nvld), 32'd64);

    // 3) rate 16/21 puncturing; config changes after first pair ignored
    clr();
    pb_size = 2'd0; code_rate = 1'b1;
    send(rnd2(), rnd2());
    code_rate = 1'b0; pb_size = 2'd2;
    repeat (63) send(rnd2(), rnd2());
    idle(3);
    chk("t3_keep", 32'(nkeep), 32'd40);
    chk("t3_nvld", 32'(nvld), 32'd64);
    chk("t3_ndone", 32'(ndone), 32'd1);

    // 4) 544 pairs with valid gaps
    clr();
    pb_size = 2'd1; code_rate = 1'b0;
    for (int i = 0; i < 544; i++) begin
      send(rnd2(), rnd2());
      idle(1);
    end
    idle(3);
    chk("t4_nvld", 32'(nvld), 32'd544);
    chk("t4_nlast", 32'(nlast), 32'd1);
    chk("t4_ndone", 32'(ndone), 32'd1);

    // 5) reset mid-PB then a fresh PB
    clr();
    pb_size = 2'd0;
    repeat (30) send(rnd2(), rnd2());
    @(negedge clk); #1;
    do_reset();
    chk("t5_rst", 32'({dout_vld, pb_last, pb_done, sys, p1, p2}), 32'd0);
    chk("t5_part", 32'(nvld), 32'd30);
    clr();
    repeat (64) send(2'b00, 2'b00);
    idle(3);
    chk("t5_nvld", 32'(nvld), 32'd64);
    chk("t5_nlast", 32'(nlast), 32'd1);
    chk("t5_ndone", 32'(ndone), 32'd1);

    // 6) illegal size
    clr();
    pb_size = 2'd3;
    repeat (10) send(rnd2(), rnd2());
    pb_size = 2'd0;
    repeat (5) send(rnd2(), rnd2());
    idle(3);
    chk("t6_cfg_err", 32'(cfg_err), 32'd1);
    chk("t6_nvld", 32'(nvld), 32'd0);
    do_reset();
    chk("t6_cfg_clr", 32'(cfg_err), 32'd0);

    idle(3);
    chk("q_empty", 32'(q.size()), 32'd0);
    chk("fq_empty", 32'(fq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule
